gb_alu_seq: RTL and testbench

- Clocked, handshaked successor to the combinational/event-triggered CPU ALU: one op per start pulse, registered result, flags and flag write-enable.
- Parametrised data width; completes SUB/SBC/CP, DAA, BIT/RES/SET.
- Adds a two-pass wide add (ADD HL,rr style). Sits between the decoder/sequencer and the register file/F register.

---
 rtl/gb_alu_seq.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_gb_alu_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gb_alu_seq.sv
// gb_alu_seq: clocked, handshaked CPU ALU. One operation per start pulse;
// result, new flags and flag write-enable are registered and presented
// with a single-cycle done pulse.
//
// Optional build macro GB_ALU_WIDE_EN: when defined, adds the EXEC_HI pass
// so a base ADD with wide=1 performs a 2*DATA_W add (ADD HL,rr style).
// When undefined, wide is ignored and every op is single-pass.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             request, accepted only while idle
//   ext, misc, op     operation select (base / misc / CB / BIT-RES-SET groups)
//   bit_sel           bit index for BIT/RES/SET
//   wide              request the two-pass wide add (base ADD only)
//   src_data          source operand (low DATA_W used when narrow)
//   dest_data         destination operand (A, or HL when wide)
//   flags_in          current F register (Z=7, N=6, H=5, C=4)
//   busy              op in flight
//   done              one-cycle pulse, res/flags_res valid
//   res               result, upper half zero when narrow
//   flags_res         new F, bits [3:0] always zero
//   wr_en_flags       pulses with done when the op writes F
//
// State | meaning
// IDLE    | waiting for start; also the done cycle
// EXEC    | main (or low-half) pass
// EXEC_HI | high-half pass of a wide add
module gb_alu_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ext,
  input  logic                  misc,
  input  logic [2:0]            op,
  input  logic [2:0]            bit_sel,
  input  logic                  wide,
  input  logic [2*DATA_W-1:0]   src_data,
  input  logic [2*DATA_W-1:0]   dest_data,
  input  logic [7:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   res,
  output logic [7:0]            flags_res,
  output logic                  wr_en_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, EXEC_HI} state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7;

  state_t state, state_nxt;

  logic              ext_q, misc_q;
  logic [2:0]        op_q, bit_q;
  logic [DATA_W-1:0] src_q, dest_q;
  logic [3:0]        flags_q;
  logic              fz, fn, fh, fc;
  logic              go_hi;

`ifdef GB_ALU_WIDE_EN
  logic              wide_q;
  logic [DATA_W-1:0] src_hi_q, dest_hi_q, res_lo_q;
  logic              carry_lo_q;
`endif

  assign fz = flags_q[3];
  assign fn = flags_q[2];
  assign fh = flags_q[1];
  assign fc = flags_q[0];

`ifdef GB_ALU_WIDE_EN
  assign go_hi = wide_q && !ext_q && !misc_q && (op_q == OP_ADD);
`else
  assign go_hi = 1'b0;
`endif

  // Shared adder: narrow ADD/ADC, low half of a wide add, and high half with
  // the carry held from the low pass.
  logic [DATA_W-1:0] add_a, add_b;
  logic              add_cin;
  logic              hi_pass;
  logic [DATA_W:0]   sum;
  logic [4:0]        hsum;

  always_comb begin
    add_a   = dest_q;
    add_b   = src_q;
    add_cin = (op_q == OP_ADC) ? fc : 1'b0;
    hi_pass = 1'b0;
`ifdef GB_ALU_WIDE_EN
    if (state == EXEC_HI) begin
      add_a   = dest_hi_q;
      add_b   = src_hi_q;
      add_cin = carry_lo_q;
      hi_pass = 1'b1;
    end
`endif
  end

  assign sum  = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  assign hsum = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]} + {4'b0, add_cin};

  // Subtractor for SUB/SBC/CP; the extra top bit is the borrow.
  logic            sub_cin;
  logic [DATA_W:0] diff;
  logic [4:0]      hdiff;

  assign sub_cin = (op_q == OP_SBC) & fc;
  assign diff  = {1'b0, dest_q} - {1'b0, src_q} - {{DATA_W{1'b0}}, sub_cin};
  assign hdiff = {1'b0, dest_q[3:0]} - {1'b0, src_q[3:0]} - {4'b0, sub_cin};

  logic [DATA_W-1:0] mask;
  assign mask = {{(DATA_W-1){1'b0}}, 1'b1} << bit_q;

  logic [DATA_W-1:0] alu_r, daa_v;
  logic              z, n, h, c, set_z, alu_wr, daa_c;

  always_comb begin
    alu_r  = dest_q;
    z      = fz;
    n      = fn;
    h      = fh;
    c      = fc;
    set_z  = 1'b0;
    alu_wr = 1'b1;
    daa_v  = dest_q;
    daa_c  = fc;
    case ({ext_q, misc_q})
      2'b00: begin
        case (op_q)
          OP_ADD, OP_ADC: begin
            alu_r = sum[DATA_W-1:0]; n = 1'b0; h = hsum[4]; c = sum[DATA_W]; set_z = 1'b1;
          end
          OP_SUB, OP_SBC: begin
            alu_r = diff[DATA_W-1:0]; n = 1'b1; h = hdiff[4]; c = diff[DATA_W]; set_z = 1'b1;
          end
          OP_AND: begin
            alu_r = dest_q & src_q; n = 1'b0; h = 1'b1; c = 1'b0; set_z = 1'b1;
          end
          OP_XOR: begin
            alu_r = dest_q ^ src_q; n = 1'b0; h = 1'b0; c = 1'b0; set_z = 1'b1;
          end
          OP_OR: begin
            alu_r = dest_q | src_q; n = 1'b0; h = 1'b0; c = 1'b0; set_z = 1'b1;
          end
          default: begin  // CP: compare only, result is the unchanged destination
            alu_r = dest_q; n = 1'b1; h = hdiff[4]; c = diff[DATA_W];
            z = (diff[DATA_W-1:0] == '0);
          end
        endcase
      end
      2'b01: begin
        case (op_q)
          3'd0: begin alu_r = {dest_q[DATA_W-2:0], dest_q[DATA_W-1]}; c = dest_q[DATA_W-1]; end
          3'd1: begin alu_r = {dest_q[0], dest_q[DATA_W-1:1]};        c = dest_q[0]; end
          3'd2: begin alu_r = {dest_q[DATA_W-2:0], fc};               c = dest_q[DATA_W-1]; end
          3'd3: begin alu_r = {fc, dest_q[DATA_W-1:1]};               c = dest_q[0]; end
          3'd4: begin
            if (DATA_W == 8) begin
              if (!fn) begin
                if (fc || dest_q > DATA_W'(8'h99)) begin
                  daa_v = daa_v + DATA_W'(8'h60);
                  daa_c = 1'b1;
                end
                if (fh || dest_q[3:0] > 4'd9) daa_v = daa_v + DATA_W'(8'h06);
              end else begin
                if (fc) daa_v = daa_v - DATA_W'(8'h60);
                if (fh) daa_v = daa_v - DATA_W'(8'h06);
              end
              alu_r = daa_v; h = 1'b0; c = daa_c; set_z = 1'b1;
            end
          end
          3'd5: begin alu_r = ~dest_q; n = 1'b1; h = 1'b1; end
          3'd6: begin n = 1'b0; h = 1'b0; c = 1'b1; end
          default: begin n = 1'b0; h = 1'b0; c = ~fc; end
        endcase
        // Accumulator rotates always clear Z, unlike their CB counterparts.
        if (op_q[2] == 1'b0) begin
          z = 1'b0; n = 1'b0; h = 1'b0;
        end
      end
      2'b10: begin
        n = 1'b0; h = 1'b0; set_z = 1'b1;
        case (op_q)
          3'd0: begin alu_r = {src_q[DATA_W-2:0], src_q[DATA_W-1]}; c = src_q[DATA_W-1]; end
          3'd1: begin alu_r = {src_q[0], src_q[DATA_W-1:1]};       c = src_q[0]; end
          3'd2: begin alu_r = {src_q[DATA_W-2:0], fc};             c = src_q[DATA_W-1]; end
          3'd3: begin alu_r = {fc, src_q[DATA_W-1:1]};             c = src_q[0]; end
          3'd4: begin alu_r = {src_q[DATA_W-2:0], 1'b0};           c = src_q[DATA_W-1]; end
          3'd5: begin alu_r = {src_q[DATA_W-1], src_q[DATA_W-1:1]}; c = src_q[0]; end
          3'd6: begin alu_r = {src_q[DATA_W/2-1:0], src_q[DATA_W-1:DATA_W/2]}; c = 1'b0; end
          default: begin alu_r = {1'b0, src_q[DATA_W-1:1]};        c = src_q[0]; end
        endcase
      end
      default: begin
        alu_r = src_q;
        case (op_q[1:0])
          2'b01: begin z = ~src_q[bit_q]; n = 1'b0; h = 1'b1; end
          2'b10: begin alu_r = src_q & ~mask; alu_wr = 1'b0; end
          2'b11: begin alu_r = src_q | mask;  alu_wr = 1'b0; end
          default: alu_wr = 1'b0;
        endcase
      end
    endcase
    if (set_z) z = (alu_r == '0);
    // High pass of a wide add: only H/C/N change, Z is left as it was.
    if (hi_pass) begin
      alu_r = sum[DATA_W-1:0]; z = fz; n = 1'b0; h = hsum[4]; c = sum[DATA_W]; alu_wr = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXEC;
      EXEC:    state_nxt = go_hi ? EXEC_HI : IDLE;
      EXEC_HI: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q       <= 1'b0;
      misc_q      <= 1'b0;
      op_q        <= '0;
      bit_q       <= '0;
      src_q       <= '0;
      dest_q      <= '0;
      flags_q     <= '0;
      done        <= 1'b0;
      wr_en_flags <= 1'b0;
      res         <= '0;
      flags_res   <= '0;
`ifdef GB_ALU_WIDE_EN
      wide_q      <= 1'b0;
      src_hi_q    <= '0;
      dest_hi_q   <= '0;
      res_lo_q    <= '0;
      carry_lo_q  <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      wr_en_flags <= 1'b0;
      if (state == IDLE && start) begin
        ext_q   <= ext;
        misc_q  <= misc;
        op_q    <= op;
        bit_q   <= bit_sel;
        src_q   <= src_data[DATA_W-1:0];
        dest_q  <= dest_data[DATA_W-1:0];
        flags_q <= flags_in[7:4];
`ifdef GB_ALU_WIDE_EN
        wide_q    <= wide;
        src_hi_q  <= src_data[2*DATA_W-1:DATA_W];
        dest_hi_q <= dest_data[2*DATA_W-1:DATA_W];
`endif
      end
`ifdef GB_ALU_WIDE_EN
      if (state == EXEC && go_hi) begin
        res_lo_q   <= sum[DATA_W-1:0];
        carry_lo_q <= sum[DATA_W];
      end
`endif
      if ((state == EXEC && !go_hi) || state == EXEC_HI) begin
        done        <= 1'b1;
        wr_en_flags <= alu_wr;
        flags_res   <= {z, n, h, c, 4'b0000};
        res         <= {{DATA_W{1'b0}}, alu_r};
`ifdef GB_ALU_WIDE_EN
        if (state == EXEC_HI) res <= {alu_r, res_lo_q};
`endif
      end
    end
  end

  logic unused_bits;
`ifdef GB_ALU_WIDE_EN
  assign unused_bits = ^{flags_in[3:0], hsum[3:0], hdiff[3:0]};
`else
  assign unused_bits = ^{flags_in[3:0], hsum[3:0], hdiff[3:0], wide,
                         src_data[2*DATA_W-1:DATA_W], dest_data[2*DATA_W-1:DATA_W]};
`endif

endmodule

// File: tb/tb_gb_alu_seq.sv
module tb_gb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ext, misc, wide;
  logic [2:0]  op, bit_sel;
  logic [15:0] src_data, dest_data;
  logic [7:0]  flags_in;
  logic        busy, done, wr_en_flags;
  logic [15:0] res;
  logic [7:0]  flags_res;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int lat;
  logic seen_done;

  gb_alu_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ext(ext), .misc(misc), .op(op),
    .bit_sel(bit_sel), .wide(wide), .src_data(src_data), .dest_data(dest_data),
    .flags_in(flags_in), .busy(busy), .done(done), .res(res),
    .flags_res(flags_res), .wr_en_flags(wr_en_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an op at a negedge with start raised; accepted at the next posedge.
  task automatic issue(input logic e, input logic m, input logic [2:0] o, input logic [2:0] b,
                       input logic w, input logic [15:0] s, input logic [15:0] d,
                       input logic [7:0] f);
    ext = e; misc = m; op = o; bit_sel = b; wide = w;
    src_data = s; dest_data = d; flags_in = f; start = 1'b1;
  endtask

  // Returns the number of negedges from issue until done is seen (bounded).
  task automatic wait_done(output int l);
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (done !== 1'b1 && l < 8) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ext = 1'b0; misc = 1'b0; wide = 1'b0;
    op = 3'd0; bit_sel = 3'd0; src_data = '0; dest_data = '0; flags_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_flags", flags_res, 0);
    chk("rst_wr", wr_en_flags, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 0x3A + 0xC6
    issue(0, 0, 3'd0, 0, 0, 16'h00C6, 16'h003A, 8'h00);
    @(negedge clk);
    start = 1'b0;
    chk("add_busy", busy, 1);
    chk("add_early_done", done, 0);
    @(negedge clk);
    chk("add_done", done, 1);
    chk("add_res", res, 16'h0000);
    chk("add_flags", flags_res, 8'hB0);
    chk("add_wr", wr_en_flags, 1);
    chk("add_busy_end", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("wr_pulse", wr_en_flags, 0);

    issue(0, 0, 3'd2, 0, 0, 16'h003E, 16'h003E, 8'h00);
    wait_done(lat);
    chk("sub_lat", lat, 2);
    chk("sub_res", res, 16'h0000);
    chk("sub_flags", flags_res, 8'hC0);

    issue(0, 0, 3'd7, 0, 0, 16'h0040, 16'h003E, 8'h00);
    wait_done(lat);
    chk("cp_res", res, 16'h003E);
    chk("cp_flags", flags_res, 8'h50);

    // ADD then DAA issued in the ADD's done cycle
    issue(0, 0, 3'd0, 0, 0, 16'h0038, 16'h0045, 8'h00);
    wait_done(lat);
    chk("add2_res", res, 16'h007D);
    chk("add2_flags", flags_res, 8'h00);
    issue(0, 1, 3'd4, 0, 0, 16'h0000, 16'h007D, 8'h00);
    wait_done(lat);
    chk("daa_lat", lat, 2);
    chk("daa_res", res, 16'h0083);
    chk("daa_flags", flags_res, 8'h00);

    issue(0, 0, 3'd3, 0, 0, 16'h0001, 16'h0010, 8'h10);
    wait_done(lat);
    chk("sbc_res", res, 16'h000E);
    chk("sbc_flags", flags_res, 8'h60);

    issue(0, 0, 3'd1, 0, 0, 16'h0000, 16'h00FF, 8'h10);
    wait_done(lat);
    chk("adc_res", res, 16'h0000);
    chk("adc_flags", flags_res, 8'hB0);

    issue(0, 0, 3'd5, 0, 0, 16'h005A, 16'h005A, 8'h70);
    wait_done(lat);
    chk("xor_res", res, 16'h0000);
    chk("xor_flags", flags_res, 8'h80);

    issue(0, 1, 3'd0, 0, 0, 16'h0000, 16'h0085, 8'hF0);
    wait_done(lat);
    chk("rlca_res", res, 16'h000B);
    chk("rlca_flags", flags_res, 8'h10);

    issue(0, 1, 3'd5, 0, 0, 16'h0000, 16'h0035, 8'h90);
    wait_done(lat);
    chk("cpl_res", res, 16'h00CA);
    chk("cpl_flags", flags_res, 8'hF0);

    issue(0, 1, 3'd7, 0, 0, 16'h0000, 16'h0011, 8'h90);
    wait_done(lat);
    chk("ccf_flags", flags_res, 8'h80);

    issue(1, 0, 3'd6, 0, 0, 16'h00F1, 16'h0000, 8'h10);
    wait_done(lat);
    chk("swap_res", res, 16'h001F);
    chk("swap_flags", flags_res, 8'h00);

    issue(1, 0, 3'd7, 0, 0, 16'h0001, 16'h0000, 8'h00);
    wait_done(lat);
    chk("srl_res", res, 16'h0000);
    chk("srl_flags", flags_res, 8'h90);

    issue(1, 1, 3'b001, 3'd7, 0, 16'h007F, 16'h0000, 8'h10);
    wait_done(lat);
    chk("bit_res", res, 16'h007F);
    chk("bit_flags", flags_res, 8'hB0);
    chk("bit_wr", wr_en_flags, 1);

    issue(1, 1, 3'b011, 3'd0, 0, 16'h0000, 16'h0000, 8'h00);
    wait_done(lat);
    chk("set_res", res, 16'h0001);
    chk("set_wr", wr_en_flags, 0);

    issue(1, 1, 3'b010, 3'd7, 0, 16'h00FF, 16'h0000, 8'h00);
    wait_done(lat);
    chk("res_res", res, 16'h007F);
    chk("res_wr", wr_en_flags, 0);

`ifdef GB_ALU_WIDE_EN
    issue(0, 0, 3'd0, 0, 1, 16'h0605, 16'h8A23, 8'h80);
    wait_done(lat);
    chk("wide_lat", lat, 3);
    chk("wide_res", res, 16'h9028);
    chk("wide_flags", flags_res, 8'hA0);
    issue(0, 0, 3'd0, 0, 1, 16'h0001, 16'hFFFF, 8'h80);
    wait_done(lat);
    chk("wide2_lat", lat, 3);
    chk("wide2_res", res, 16'h0000);
    chk("wide2_flags", flags_res, 8'hB0);
`else
    issue(0, 0, 3'd0, 0, 1, 16'h0605, 16'h8A23, 8'h80);
    wait_done(lat);
    chk("nowide_lat", lat, 2);
    chk("nowide_res", res, 16'h0028);
    chk("nowide_flags", flags_res, 8'h00);
    issue(0, 0, 3'd0, 0, 1, 16'h0001, 16'hFFFF, 8'h80);
    wait_done(lat);
    chk("nowide2_res", res, 16'h0000);
    chk("nowide2_flags", flags_res, 8'hB0);
`endif

    // start held while busy, with different operands: must be ignored
    issue(0, 0, 3'd4, 0, 0, 16'h003C, 16'h00F0, 8'h00);
    @(negedge clk);
    chk("busy_hold", busy, 1);
    op = 3'd5; src_data = 16'h00FF; dest_data = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done", done, 1);
    chk("ign_res", res, 16'h0030);
    chk("ign_flags", flags_res, 8'h20);
    @(negedge clk);
    chk("ign_no_2nd", done, 0);
    chk("ign_busy", busy, 0);
    chk("ign_res_hold", res, 16'h0030);

    // Reset mid-operation
`ifdef GB_ALU_WIDE_EN
    issue(0, 0, 3'd0, 0, 1, 16'h0605, 16'h8A23, 8'h80);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
`else
    issue(0, 0, 3'd0, 0, 0, 16'h0034, 16'h0012, 8'h00);
    @(negedge clk);
    start = 1'b0;
`endif
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_flags", flags_res, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("rst_no_done", seen_done, 0);

    issue(0, 0, 3'd0, 0, 0, 16'h0001, 16'h000F, 8'h00);
    wait_done(lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_res", res, 16'h0010);
    chk("post_rst_flags", flags_res, 8'h20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
